// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the L2 cache way array and its flush controller:
//   - default geometry (index width, tag width, line size)
//   - request opcode encodings
//   - flush FSM state encodings
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int INDEX_BITS_DEF = 14;
    localparam int TAG_BITS_DEF   = 14;
    localparam int LINE_SIZE_DEF  = 512;

    typedef logic [1:0] op_t;

    localparam op_t OP_LOOKUP = 2'd0;
    localparam op_t OP_FILL   = 2'd1;
    localparam op_t OP_WRITE  = 2'd2;
    localparam op_t OP_INVAL  = 2'd3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/way_flush_ctrl.sv
// -----------------------------------------------------------------------------
// way_flush_ctrl
// IDLE/FLUSH state machine that walks every set of one cache way, one set per
// cycle, so the owner can clear that set's valid and dirty state.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   flush_start  - begin a flush (ignored while one is running)
//   flush_busy   - high for exactly 2^indexBits cycles per flush
//   clr_en       - clear the set at clr_idx this cycle
//   clr_idx      - set currently being cleared
// -----------------------------------------------------------------------------
module way_flush_ctrl
    import cache_pkg::*;
#(
    parameter int indexBits = INDEX_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_start,
    output logic                 flush_busy,
    output logic                 clr_en,
    output logic [indexBits-1:0] clr_idx
);

    localparam logic [indexBits-1:0] CNT_LAST = {indexBits{1'b1}};
    localparam logic [indexBits-1:0] CNT_ZERO = {indexBits{1'b0}};
    localparam logic [indexBits-1:0] CNT_ONE  = {{(indexBits-1){1'b0}}, 1'b1};

    logic [0:0]           state_r;
    logic [indexBits-1:0] cnt_r;

    // Flush state and set counter; the last set is cleared on the cycle the FSM leaves FLUSH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_start) begin
                        state_r <= ST_FLUSH;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_FLUSH: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign flush_busy = (state_r == ST_FLUSH);
    assign clr_en     = (state_r == ST_FLUSH);
    assign clr_idx    = cnt_r;

endmodule

// File: rtl/cache_way_array.sv
// -----------------------------------------------------------------------------
// cache_way_array
// One direct-indexed way of the L2 cache model: 2^indexBits lines of
// tag/data/valid/dirty, one request per cycle, registered response reporting
// the line state as it was before the operation, plus a whole-way flush.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake (ready drops during/at flush)
//   req_op              - LOOKUP / FILL / WRITE / INVALIDATE
//   req_index/tag/data  - set index, tag, line data
//   resp_valid          - one-cycle pulse, one cycle after acceptance
//   resp_hit/dirty/tag/data - pre-op hit, dirty bit, stored tag and data
//   resp_perr           - (WAY_PARITY_EN only) stored parity mismatch on a valid line
//   flush_start/busy    - start and progress of the flush walk
// Optional feature: define WAY_PARITY_EN to keep one even-parity bit per line
// over {tag, data} and report mismatches on resp_perr.
// -----------------------------------------------------------------------------
module cache_way_array
    import cache_pkg::*;
#(
    parameter int indexBits = INDEX_BITS_DEF,
    parameter int tagBits   = TAG_BITS_DEF,
    parameter int lineSize  = LINE_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [indexBits-1:0] req_index,
    input  logic [tagBits-1:0]   req_tag,
    input  logic [lineSize-1:0]  req_data,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic                 resp_dirty,
    output logic [tagBits-1:0]   resp_tag,
    output logic [lineSize-1:0]  resp_data,
`ifdef WAY_PARITY_EN
    output logic                 resp_perr,
`endif
    input  logic                 flush_start,
    output logic                 flush_busy
);

    localparam int DEPTH = 2 ** indexBits;

    logic [tagBits-1:0]   tag_mem_r  [DEPTH];
    logic [lineSize-1:0]  data_mem_r [DEPTH];
    logic [DEPTH-1:0]     valid_r;
    logic [DEPTH-1:0]     dirty_r;

    logic                 accept_s;
    logic                 hit_s;
    logic                 rd_valid_s;
    logic                 rd_dirty_s;
    logic [tagBits-1:0]   rd_tag_s;
    logic [lineSize-1:0]  rd_data_s;
    logic                 clr_en_s;
    logic [indexBits-1:0] clr_idx_s;

`ifdef WAY_PARITY_EN
    logic                 par_mem_r [DEPTH];
    logic                 perr_s;

    function automatic logic line_parity(input logic [tagBits+lineSize-1:0] bits);
        return ^bits;
    endfunction
`endif

    way_flush_ctrl #(
        .indexBits (indexBits)
    ) u_flush (
        .clk         (clk),
        .reset       (reset),
        .flush_start (flush_start),
        .flush_busy  (flush_busy),
        .clr_en      (clr_en_s),
        .clr_idx     (clr_idx_s)
    );

    // A flush request takes priority over a request in the same cycle.
    assign req_ready = !flush_busy && !flush_start;
    assign accept_s  = req_valid && req_ready;

    // Read the addressed line as it stands before this cycle's operation.
    always_comb begin
        rd_tag_s   = tag_mem_r[req_index];
        rd_data_s  = data_mem_r[req_index];
        rd_valid_s = valid_r[req_index];
        rd_dirty_s = dirty_r[req_index];
        hit_s      = rd_valid_s && (rd_tag_s == req_tag);
`ifdef WAY_PARITY_EN
        perr_s     = rd_valid_s && (line_parity({rd_tag_s, rd_data_s}) != par_mem_r[req_index]);
`endif
    end

    // Valid/dirty state; flush clears never overlap an accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
            dirty_r <= {DEPTH{1'b0}};
        end else if (clr_en_s) begin
            valid_r[clr_idx_s] <= 1'b0;
            dirty_r[clr_idx_s] <= 1'b0;
        end else if (accept_s) begin
            case (req_op)
                OP_FILL: begin
                    valid_r[req_index] <= 1'b1;
                    dirty_r[req_index] <= 1'b0;
                end
                OP_WRITE: begin
                    if (hit_s) begin
                        dirty_r[req_index] <= 1'b1;
                    end
                end
                OP_INVAL: begin
                    valid_r[req_index] <= 1'b0;
                    dirty_r[req_index] <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag/data (and parity) storage is intentionally not reset; valid gates its use.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            case (req_op)
                OP_FILL: begin
                    tag_mem_r[req_index]  <= req_tag;
                    data_mem_r[req_index] <= req_data;
`ifdef WAY_PARITY_EN
                    par_mem_r[req_index]  <= line_parity({req_tag, req_data});
`endif
                end
                OP_WRITE: begin
                    if (hit_s) begin
                        data_mem_r[req_index] <= req_data;
`ifdef WAY_PARITY_EN
                        par_mem_r[req_index]  <= line_parity({rd_tag_s, req_data});
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response register: pulses valid, holds fields until the next accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_dirty <= 1'b0;
            resp_tag   <= {tagBits{1'b0}};
            resp_data  <= {lineSize{1'b0}};
`ifdef WAY_PARITY_EN
            resp_perr  <= 1'b0;
`endif
        end else begin
            resp_valid <= accept_s;
            if (accept_s) begin
                resp_hit   <= hit_s;
                resp_dirty <= rd_dirty_s;
                resp_tag   <= rd_tag_s;
                resp_data  <= rd_data_s;
`ifdef WAY_PARITY_EN
                resp_perr  <= perr_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cache_way_array.sv
// -----------------------------------------------------------------------------
// tb_cache_way_array
// Self-checking bench for cache_way_array (indexBits=3, tagBits=8, lineSize=32).
// Requests are driven on the falling edge; the expected response is queued at
// drive time and popped by a monitor that samples on later falling edges.
// -----------------------------------------------------------------------------
module tb_cache_way_array;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_index;
    logic [7:0]  req_tag;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_dirty;
    logic [7:0]  resp_tag;
    logic [31:0] resp_data;
    logic        flush_start;
    logic        flush_busy;
`ifdef WAY_PARITY_EN
    logic        resp_perr;
`endif

    cache_way_array #(
        .indexBits (3),
        .tagBits   (8),
        .lineSize  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_index   (req_index),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_dirty  (resp_dirty),
        .resp_tag    (resp_tag),
        .resp_data   (resp_data),
`ifdef WAY_PARITY_EN
        .resp_perr   (resp_perr),
`endif
        .flush_start (flush_start),
        .flush_busy  (flush_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  idx;
        logic [7:0]  tag;
        logic [31:0] data;
        logic        hit;
        logic        dirty;
        logic        chk;
        logic [7:0]  etag;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        int          id;
        logic        hit;
        logic        dirty;
        logic        chk;
        logic [7:0]  tag;
        logic [31:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[14];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt;
    logic done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (case %0d): got 0x%0h, expected 0x%0h", name, id, got, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input logic hit, input logic dirty, input logic chk,
                                input logic [7:0] tag, input logic [31:0] data, input logic perr);
        exp_t e;
        e.id = id; e.hit = hit; e.dirty = dirty; e.chk = chk;
        e.tag = tag; e.data = data; e.perr = perr; e.cyc = 0;
        return e;
    endfunction

    // Drive one request on the falling edge; leaves req_valid high for back-to-back use.
    task automatic send(input logic [1:0] op, input logic [2:0] idx, input logic [7:0] tag,
                        input logic [31:0] data, input exp_t e);
        exp_t q;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        req_tag   = tag;
        req_data  = data;
        #1;
        check("req_ready", e.id, {31'b0, req_ready}, 32'd1);
        q = e;
        q.cyc = cyc + 1;
        sb_q.push_back(q);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, 0, sb_q.size(), 32'd0);
    endtask

    // Response monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", -1, {31'b0, resp_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_latency", mon_e.id, cyc, mon_e.cyc);
                check("resp_hit", mon_e.id, {31'b0, resp_hit}, {31'b0, mon_e.hit});
                check("resp_dirty", mon_e.id, {31'b0, resp_dirty}, {31'b0, mon_e.dirty});
                if (mon_e.chk) begin
                    check("resp_tag", mon_e.id, {24'b0, resp_tag}, {24'b0, mon_e.tag});
                    check("resp_data", mon_e.id, resp_data, mon_e.data);
                end
`ifdef WAY_PARITY_EN
                check("resp_perr", mon_e.id, {31'b0, resp_perr}, {31'b0, mon_e.perr});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = OP_LOOKUP;
        req_index   = 3'd0;
        req_tag     = 8'h00;
        req_data    = 32'h0;
        flush_start = 1'b0;

        // Single-index sequence on sets 5 and 2; expectations are pre-op state.
        vecs[0]  = '{OP_LOOKUP, 3'd5, 8'h12, 32'h0,        1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
        vecs[1]  = '{OP_FILL,   3'd5, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
        vecs[2]  = '{OP_LOOKUP, 3'd5, 8'h12, 32'h0,        1'b1, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF};
        vecs[3]  = '{OP_WRITE,  3'd5, 8'h12, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF};
        vecs[4]  = '{OP_WRITE,  3'd5, 8'h34, 32'h0,        1'b0, 1'b1, 1'b1, 8'h12, 32'hCAFEF00D};
        vecs[5]  = '{OP_LOOKUP, 3'd5, 8'h12, 32'h0,        1'b1, 1'b1, 1'b1, 8'h12, 32'hCAFEF00D};
        vecs[6]  = '{OP_FILL,   3'd5, 8'h77, 32'h11223344, 1'b0, 1'b1, 1'b1, 8'h12, 32'hCAFEF00D};
        vecs[7]  = '{OP_LOOKUP, 3'd5, 8'h77, 32'h0,        1'b1, 1'b0, 1'b1, 8'h77, 32'h11223344};
        vecs[8]  = '{OP_INVAL,  3'd5, 8'h77, 32'h0,        1'b1, 1'b0, 1'b1, 8'h77, 32'h11223344};
        vecs[9]  = '{OP_LOOKUP, 3'd5, 8'h77, 32'h0,        1'b0, 1'b0, 1'b1, 8'h77, 32'h11223344};
        vecs[10] = '{OP_FILL,   3'd2, 8'hAB, 32'h00000002, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
        vecs[11] = '{OP_WRITE,  3'd2, 8'hAB, 32'h5555AAAA, 1'b1, 1'b0, 1'b1, 8'hAB, 32'h00000002};
        vecs[12] = '{OP_INVAL,  3'd2, 8'hAB, 32'h0,        1'b1, 1'b1, 1'b1, 8'hAB, 32'h5555AAAA};
        vecs[13] = '{OP_LOOKUP, 3'd2, 8'hAB, 32'h0,        1'b0, 1'b0, 1'b1, 8'hAB, 32'h5555AAAA};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp_valid", 0, {31'b0, resp_valid}, 32'd0);
        check("reset_resp_hit", 0, {31'b0, resp_hit}, 32'd0);
        check("reset_resp_dirty", 0, {31'b0, resp_dirty}, 32'd0);
        check("reset_resp_tag", 0, {24'b0, resp_tag}, 32'd0);
        check("reset_resp_data", 0, resp_data, 32'd0);
        check("reset_flush_busy", 0, {31'b0, flush_busy}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].idx, vecs[i].tag, vecs[i].data,
                 mk(i, vecs[i].hit, vecs[i].dirty, vecs[i].chk, vecs[i].etag, vecs[i].edata, 1'b0));
        end
        idle();
        drain("drain_table");

        // Fill every set, confirm hits, dirty set 0, then flush.
        for (int i = 0; i < 8; i++) begin
            send(OP_FILL, 3'(i), 8'(8'h40 + i), 32'(32'h1000 + i), mk(100 + i, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0));
        end
        for (int i = 0; i < 8; i++) begin
            send(OP_LOOKUP, 3'(i), 8'(8'h40 + i), 32'h0,
                 mk(110 + i, 1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 32'(32'h1000 + i), 1'b0));
        end
        send(OP_WRITE, 3'd0, 8'h40, 32'h9, mk(120, 1'b1, 1'b0, 1'b1, 8'h40, 32'h1000, 1'b0));
        idle();
        drain("drain_fill");

        @(negedge clk);
        flush_start = 1'b1;
        req_valid   = 1'b1;
        req_op      = OP_LOOKUP;
        req_index   = 3'd1;
        req_tag     = 8'h41;
        #1;
        check("req_ready_at_flush_start", 0, {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        flush_start = 1'b0;
        req_valid   = 1'b0;
        busy_cnt    = 0;
        done        = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (flush_busy) begin
                busy_cnt++;
                if (busy_cnt == 1) begin
                    check("req_ready_during_flush", 0, {31'b0, req_ready}, 32'd0);
                end
                flush_start = (busy_cnt == 4);
            end else if (busy_cnt > 0) begin
                done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        flush_start = 1'b0;
        check("flush_busy_cycles", 0, busy_cnt, 32'd8);

        for (int i = 0; i < 8; i++) begin
            send(OP_LOOKUP, 3'(i), 8'(8'h40 + i), 32'h0,
                 mk(130 + i, 1'b0, 1'b0, 1'b1, 8'(8'h40 + i), (i == 0) ? 32'h9 : 32'(32'h1000 + i), 1'b0));
        end
        idle();
        drain("drain_flush");

        // Refill, start a flush, then reset in its third cycle.
        for (int i = 0; i < 8; i++) begin
            send(OP_FILL, 3'(i), 8'(8'h50 + i), 32'(32'h2000 + i), mk(140 + i, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0));
        end
        idle();
        drain("drain_refill");
        @(negedge clk);
        flush_start = 1'b1;
        @(negedge clk);
        flush_start = 1'b0;
        busy_cnt    = 0;
        for (int k = 0; k < 40 && busy_cnt < 3; k++) begin
            if (flush_busy) busy_cnt++;
            if (busy_cnt < 3) @(negedge clk);
        end
        check("flush_reached_cycle3", 0, busy_cnt, 32'd3);
        reset = 1'b1;
        #1;
        check("flush_busy_on_reset", 0, {31'b0, flush_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("req_ready_after_reset", 0, {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(OP_LOOKUP, 3'(i), 8'(8'h50 + i), 32'h0,
                 mk(150 + i, 1'b0, 1'b0, 1'b1, 8'(8'h50 + i), 32'(32'h2000 + i), 1'b0));
        end
        idle();
        drain("drain_reset_flush");

`ifdef WAY_PARITY_EN
        send(OP_FILL, 3'd6, 8'h66, 32'h0F0F0F0F, mk(160, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0));
        send(OP_LOOKUP, 3'd6, 8'h66, 32'h0, mk(161, 1'b1, 1'b0, 1'b1, 8'h66, 32'h0F0F0F0F, 1'b0));
        idle();
        drain("drain_parity_ok");
        dut.data_mem_r[6] = dut.data_mem_r[6] ^ 32'h8;
        send(OP_LOOKUP, 3'd6, 8'h66, 32'h0, mk(162, 1'b1, 1'b0, 1'b1, 8'h66, 32'h0F0F0F07, 1'b1));
        idle();
        drain("drain_parity_err");
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_way_array.md
Name: cache_way_array

Overview:
- One parametrised way of the L2 cache model: a direct-indexed array of 2^indexBits lines, each holding tag, data, valid and dirty state.
- Accepts one operation per cycle: lookup, fill, write or invalidate.
- Returns a registered response with hit/dirty/victim information.
- Includes a flush engine that walks every set to clear state.
- Instantiated once per way by the set-associative controller.

Parameters:
- indexBits, 14, set index width; depth = 2^indexBits lines
- tagBits, 14, stored tag width
- lineSize, 512, data bits per line

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when req_valid && req_ready
- req_op  input  2  0 LOOKUP, 1 FILL, 2 WRITE, 3 INVALIDATE
- req_index  input  indexBits  set index
- req_tag  input  tagBits  tag to compare or store
- req_data  input  lineSize  fill/write data
- resp_valid  output  1  one-cycle pulse carrying the response
- resp_hit  output  1  line was valid and its tag matched (pre-op state)
- resp_dirty  output  1  pre-op dirty bit of the line
- resp_tag  output  tagBits  pre-op stored tag (victim tag)
- resp_data  output  lineSize  pre-op stored data (read or victim data)
- flush_start  input  1  begin clearing all lines
- flush_busy  output  1  flush in progress

Behaviour:
- Reset (async):
  - All valid and dirty bits clear.
  - resp_valid, resp_hit, resp_dirty and flush_busy go to 0.
  - resp_tag and resp_data go to 0.
  - The flush counter clears.
  - Tag and data arrays are not reset.
- req_ready = !flush_busy && !flush_start (combinational).
- Latency: an accepted request at edge N produces resp_valid=1 for exactly one cycle after edge N+1. There is no backpressure on the response. Response fields hold until the next response.
- hit = valid[idx] && tag[idx]==req_tag. All response fields report state before the operation.
- Operations:
  - LOOKUP: no state change.
  - FILL: tag[idx]=req_tag, data[idx]=req_data, valid=1, dirty=0, regardless of hit. The response exposes the victim.
  - WRITE: on hit, data[idx]=req_data and dirty=1. On miss, no state change and resp_hit=0.
  - INVALIDATE: valid=0 and dirty=0. The response returns the prior tag, data and dirty bit for writeback.
- Back-to-back requests to the same index: the second sees the state written by the first. Array write precedes the next read, so no stale read is allowed.
- Flush FSM:
  - States: IDLE and FLUSH.
  - IDLE -> FLUSH on flush_start. The counter loads 0 and flush_busy is 1 from the next cycle.
  - In FLUSH, each cycle clears valid[cnt] and dirty[cnt], then increments cnt.
  - At cnt = 2^indexBits-1, that line is cleared and the FSM returns to IDLE.
  - flush_busy is high for exactly 2^indexBits cycles.
  - flush_start during FLUSH is ignored. flush_start coincident with req_valid: flush wins and the request is not accepted.
  - A flush does not cancel a response already in flight.
- Reset mid-flush aborts to IDLE with all valid bits clear.
- Unused req_op values: none exist, since all four 2-bit encodings are defined.

Optional Feature:
- Macro WAY_PARITY_EN.
- When defined:
  - One even-parity bit per line is stored over {tag, data}, computed on FILL and WRITE.
  - Added output port resp_perr (1 bit) asserts with resp_valid when the line is valid and its recomputed parity mismatches.
  - resp_perr resets to 0.
- When undefined: no parity storage and no resp_perr port.

Decomposition:
- Shared package cache_pkg:
  - op encodings (OP_LOOKUP=0, OP_FILL=1, OP_WRITE=2, OP_INVAL=3)
  - default widths
  - flush FSM state encoding
- One natural sub-module, way_flush_ctrl: the IDLE/FLUSH FSM and counter, outputting flush_busy, clear enable and clear index.
- Storage and compare logic stay in cache_way_array.

Test Plan (indexBits=3, tagBits=8, lineSize=32 unless noted):
- Reset, then LOOKUP idx 5 tag 0x12 -> resp_valid after 1 cycle, resp_hit=0, resp_dirty=0.
- FILL idx 5 tag 0x12 data 0xDEADBEEF, then LOOKUP idx 5 tag 0x12 back-to-back -> resp_hit=1, resp_data=0xDEADBEEF, resp_dirty=0.
- WRITE idx 5 tag 0x12 data 0xCAFEF00D, then WRITE idx 5 tag 0x34 data 0x0 -> first resp_hit=1; second resp_hit=0 with no change; LOOKUP tag 0x12 returns 0xCAFEF00D, dirty=1.
- FILL idx 5 tag 0x77 over the dirty line -> resp_hit=0, resp_dirty=1, resp_tag=0x12, resp_data=0xCAFEF00D; a follow-up LOOKUP tag 0x77 shows dirty=0.
- Fill all 8 sets, pulse flush_start with req_valid high -> req_ready=0, flush_busy high exactly 8 cycles; every set then misses.
- Assert reset at flush cycle 3 -> flush_busy=0 immediately, req_ready=1 after release, all lookups miss. With WAY_PARITY_EN, force a data bit flip via backdoor -> resp_perr=1 on LOOKUP.
